// File: rtl/i2s_tx_if.sv
// Sample-source handshake and serial I2S lines between an audio source and i2s_tx.
// master = sample source / DAC side, slave = the transmitter.
interface i2s_tx_if;
    logic        i_En;
    logic [15:0] i_Aud_Left;
    logic [15:0] i_Aud_Right;
    logic        o_Sample_Req;
    logic        o_I2S_Bclk;
    logic        o_I2S_Lrclk;
    logic        o_I2S_Data;

    modport master (
        output i_En, i_Aud_Left, i_Aud_Right,
        input  o_Sample_Req, o_I2S_Bclk, o_I2S_Lrclk, o_I2S_Data
    );
    modport slave (
        input  i_En, i_Aud_Left, i_Aud_Right,
        output o_Sample_Req, o_I2S_Bclk, o_I2S_Lrclk, o_I2S_Data
    );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo frames of 32 BCLK slots, BCLK = i_Clk / (2*CLK_DIV).
// state | meaning
// IDLE  | all outputs low, divider and slot cleared, waiting for i_En
// RUN   | serialising the captured frame, one slot per BCLK period
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic    i_Clk,
    input  logic    i_Rst,
    i2s_tx_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [4:0]  slot_nxt;
    logic [31:0] frame;
    logic        sample_req;
    logic        bclk;
    logic        lrclk;
    logic        data;

    assign slot_nxt = slot + 5'd1;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            slot       <= '0;
            frame      <= '0;
            sample_req <= 1'b0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            data       <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    slot    <= '0;
                    bclk    <= 1'b0;
                    lrclk   <= 1'b0;
                    data    <= 1'b0;
                    if (bus.i_En) begin
                        state      <= RUN;
                        frame      <= {bus.i_Aud_Left, bus.i_Aud_Right};
                        sample_req <= 1'b1;
                    end
                end
                RUN: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        bclk    <= ~bclk;
                        // falling BCLK is the only slot boundary
                        if (bclk) begin
                            if (slot != 5'd31) begin
                                slot  <= slot_nxt;
                                lrclk <= slot_nxt[4];
                                data  <= frame[5'd31 - slot];
                            end else if (bus.i_En) begin
                                // one-BCLK delay: old right LSB goes out in the new slot 0
                                frame      <= {bus.i_Aud_Left, bus.i_Aud_Right};
                                slot       <= '0;
                                lrclk      <= 1'b0;
                                data       <= frame[0];
                                sample_req <= 1'b1;
                            end else begin
                                state <= IDLE;
                                slot  <= '0;
                                lrclk <= 1'b0;
                                data  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Sample_Req = sample_req;
    assign bus.o_I2S_Bclk   = bclk;
    assign bus.o_I2S_Lrclk  = lrclk;
    assign bus.o_I2S_Data   = data;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (CLK_DIV 4 and 2) checked every cycle against a frame-offset model,
// plus table-driven decoded-frame checks and hand-written enable/reset/input-change sequences.
module tb_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_v [2];
    logic [15:0] l_v [2];
    logic [15:0] r_v [2];
    logic [3:0]  obs [2];   // {req, bclk, lrclk, data}

    i2s_tx_if ifa();
    i2s_tx_if ifb();

    assign ifa.i_En        = en_v[0];
    assign ifa.i_Aud_Left  = l_v[0];
    assign ifa.i_Aud_Right = r_v[0];
    assign ifb.i_En        = en_v[1];
    assign ifb.i_Aud_Left  = l_v[1];
    assign ifb.i_Aud_Right = r_v[1];
    assign obs[0] = {ifa.o_Sample_Req, ifa.o_I2S_Bclk, ifa.o_I2S_Lrclk, ifa.o_I2S_Data};
    assign obs[1] = {ifb.o_Sample_Req, ifb.o_I2S_Bclk, ifb.o_I2S_Lrclk, ifb.o_I2S_Data};

    i2s_tx #(.CLK_DIV(4)) u_dut_a (.i_Clk(clk), .i_Rst(rst), .bus(ifa.slave));
    i2s_tx #(.CLK_DIV(2)) u_dut_b (.i_Clk(clk), .i_Rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic int div_of(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    // Reference: position within the current frame, counted in i_Clk cycles since the capture edge.
    bit          m_run [2];
    int          m_k [2];
    logic [31:0] m_F [2];
    logic        m_p [2];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_run[d] <= 1'b0;
                m_k[d]   <= 0;
                m_F[d]   <= '0;
                m_p[d]   <= 1'b0;
            end else if (!m_run[d] || m_k[d] == 64 * div_of(d) - 1) begin
                if (en_v[d]) begin
                    m_p[d]   <= m_run[d] ? m_F[d][0] : 1'b0;
                    m_F[d]   <= {l_v[d], r_v[d]};
                    m_run[d] <= 1'b1;
                    m_k[d]   <= 0;
                end else begin
                    m_run[d] <= 1'b0;
                    m_k[d]   <= 0;
                end
            end else begin
                m_k[d] <= m_k[d] + 1;
            end
        end
    end

    function automatic logic [3:0] expect_out(int d);
        int   slot;
        logic b;
        logic lr;
        logic dt;
        if (!m_run[d]) return 4'b0000;
        slot = m_k[d] / (2 * div_of(d));
        b    = ((m_k[d] / div_of(d)) % 2) == 1;
        lr   = slot >= 16;
        dt   = (slot == 0) ? m_p[d] : m_F[d][32 - slot];
        return {m_k[d] == 0, b, lr, dt};
    endfunction

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] exp_l;
        logic [14:0] exp_r_hi;
        logic        exp_s0;
    } vec_t;

    vec_t        tab [5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idx [2];
    int          req_cnt [2];
    int          last_req [2];
    int          prev_req [2];
    logic        prev_bclk [2];
    logic        prev_lr [2];
    logic [31:0] cur_bits [2];
    logic [31:0] last_bits [2];
    bit          b_prev_ok = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: sample on the falling i_Clk edge, compare with the model, decode the serial stream.
    task automatic step();
        logic [3:0] e;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e = expect_out(d);
            checks++;
            if (obs[d] !== e) begin
                errors++;
                $display("FAIL model_dut%0d: req/bclk/lr/data got %b expected %b (cycle %0d)", d, obs[d], e, cyc);
            end
            if (!rst && obs[d][1] !== prev_lr[d]) begin
                checks++;
                if (!(prev_bclk[d] && !obs[d][2])) begin
                    errors++;
                    $display("FAIL lr_edge_dut%0d: lrclk moved to %b with bclk %b->%b (cycle %0d)",
                             d, obs[d][1], prev_bclk[d], obs[d][2], cyc);
                end
            end
            if (obs[d][3]) begin
                if (d == 1) begin
                    if (b_prev_ok) check("period_b", cyc - last_req[1], 128);
                    b_prev_ok = 1'b1;
                    l_v[1] = 16'($urandom);
                    r_v[1] = 16'($urandom);
                end
                last_bits[d] = cur_bits[d];
                idx[d]       = 0;
                req_cnt[d]++;
                prev_req[d]  = last_req[d];
                last_req[d]  = cyc;
            end
            if (obs[d][2] && !prev_bclk[d]) begin
                if (idx[d] < 32) cur_bits[d][idx[d]] = obs[d][0];
                idx[d]++;
            end
            prev_bclk[d] = obs[d][2];
            prev_lr[d]   = obs[d][1];
        end
        if (rst) b_prev_ok = 1'b0;
    endtask

    task automatic wait_req(int d, int limit, string name);
        int n;
        int t;
        n = req_cnt[d];
        t = 0;
        while (req_cnt[d] == n && t < limit) begin
            step();
            t++;
        end
        checks++;
        if (req_cnt[d] == n) begin
            errors++;
            $display("FAIL %s: no Sample_Req on dut%0d within %0d cycles, got none required one", name, d, limit);
        end
    endtask

    function automatic logic [15:0] dec_left(int d);
        logic [15:0] v = '0;
        for (int j = 1; j <= 16; j++) v = {v[14:0], last_bits[d][j]};
        return v;
    endfunction

    function automatic logic [14:0] dec_right_hi(int d);
        logic [14:0] v = '0;
        for (int j = 17; j <= 31; j++) v = {v[13:0], last_bits[d][j]};
        return v;
    endfunction

    initial begin
        int n;
        tab[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 15'h1E2D, 1'b0};
        tab[1] = '{16'h8001, 16'h0001, 16'h8001, 15'h0000, 1'b0};
        tab[2] = '{16'h1234, 16'hFFFF, 16'h1234, 15'h7FFF, 1'b1};
        tab[3] = '{16'h0000, 16'h8000, 16'h0000, 15'h4000, 1'b1};
        tab[4] = '{16'hFFFF, 16'h7FFE, 16'hFFFF, 15'h3FFF, 1'b0};
        for (int d = 0; d < 2; d++) begin
            en_v[d] = 1'b0; l_v[d] = '0; r_v[d] = '0;
            idx[d] = 0; req_cnt[d] = 0; last_req[d] = 0; prev_req[d] = 0;
            prev_bclk[d] = 1'b0; prev_lr[d] = 1'b0; cur_bits[d] = '0; last_bits[d] = '0;
        end
        rst = 1'b1;

        repeat (3) step();
        check("reset_outs_a", 32'(obs[0]), 0);
        check("reset_outs_b", 32'(obs[1]), 0);
        rst = 1'b0;
        repeat (3) step();
        check("idle_outs_a", 32'(obs[0]), 0);

        // CLK_DIV=2 instance runs continuously with fresh random samples every frame
        en_v[1] = 1'b1;
        l_v[1]  = 16'($urandom);
        r_v[1]  = 16'($urandom);

        // Table: back-to-back frames, each decoded once the following capture has happened
        en_v[0] = 1'b1;
        l_v[0]  = tab[0].l;
        r_v[0]  = tab[0].r;
        wait_req(0, 1, "idle_to_run");
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                l_v[0] = tab[i + 1].l;
                r_v[0] = tab[i + 1].r;
            end
            wait_req(0, 300, "table_req");
            check("table_period", last_req[0] - prev_req[0], 256);
            check("table_left", 32'(dec_left(0)), 32'(tab[i].exp_l));
            check("table_right_hi", 32'(dec_right_hi(0)), 32'(tab[i].exp_r_hi));
            check("table_slot0", 32'(last_bits[0][0]), 32'(tab[i].exp_s0));
        end
        en_v[0] = 1'b0;
        repeat (300) step();
        check("table_idle_outs", 32'(obs[0]), 0);

        // Reset in slot 20 of a frame whose slot 0 carried a 1
        l_v[0]  = 16'h8001;
        r_v[0]  = 16'h0001;
        en_v[0] = 1'b1;
        wait_req(0, 2, "pre_rst_req1");
        wait_req(0, 300, "pre_rst_req2");
        repeat (20 * 8 + 3) step();
        check("slot20_lrclk", 32'(obs[0][1]), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_a", 32'(obs[0]), 0);
        check("rst_async_b", 32'(obs[1]), 0);
        repeat (3) step();
        rst = 1'b0;
        wait_req(0, 2, "post_rst_req1");
        wait_req(0, 300, "post_rst_req2");
        check("post_rst_slot0", 32'(last_bits[0][0]), 0);
        check("post_rst_left", 32'(dec_left(0)), 32'h8001);
        check("post_rst_right_hi", 32'(dec_right_hi(0)), 0);

        // Enable dropped in slot 5: frame completes, no further capture
        repeat (42) step();
        en_v[0] = 1'b0;
        n = req_cnt[0];
        repeat (256) step();
        check("drop_no_req", req_cnt[0], n);
        check("drop_all_slots", idx[0], 32);
        check("drop_idle_outs", 32'(obs[0]), 0);

        // Inputs change 10 cycles after capture: only the next frame sees them
        l_v[0]  = 16'h1234;
        r_v[0]  = 16'h5678;
        en_v[0] = 1'b1;
        wait_req(0, 2, "hold_req1");
        repeat (10) step();
        l_v[0] = 16'hFFFF;
        r_v[0] = 16'hFFFF;
        wait_req(0, 300, "hold_req2");
        check("hold_left", 32'(dec_left(0)), 32'h1234);
        check("hold_right_hi", 32'(dec_right_hi(0)), 32'h2B3C);
        wait_req(0, 300, "hold_req3");
        check("ones_left", 32'(dec_left(0)), 32'hFFFF);
        check("ones_right_hi", 32'(dec_right_hi(0)), 32'h7FFF);
        check("ones_slot0", 32'(last_bits[0][0]), 0);

        // Random samples, random change points, occasional idle gaps
        for (int f = 0; f < 12; f++) begin
            l_v[0]  = 16'($urandom);
            r_v[0]  = 16'($urandom);
            en_v[0] = 1'b1;
            wait_req(0, 300, "rand_req");
            repeat ($urandom_range(1, 250)) step();
            l_v[0] = 16'($urandom);
            r_v[0] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                en_v[0] = 1'b0;
                repeat (300) step();
            end
        end
        en_v[0] = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
